// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and data-memory bus of the load/store unit.
// master: drives start/isStore/op/addr/storeData and memReadData (processor + memory side)
// slave:  the unit; drives busy/done/fault/loadData and memAddress/memWriteData/memWrite/memRead
interface mem_access_unit_if;
  logic        start;
  logic        isStore;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] loadData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;
  modport master (
    output start, isStore, op, addr, storeData, memReadData,
    input  busy, done, fault, loadData, memAddress, memWriteData, memWrite, memRead
  );
  modport slave (
    input  start, isStore, op, addr, storeData, memReadData,
    output busy, done, fault, loadData, memAddress, memWriteData, memWrite, memRead
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator with read-modify-write sub-word stores.
// Ports: clock, reset_n (async active-low), bus (mem_access_unit_if.slave: request in,
// busy/done/fault/loadData out, memAddress/memWriteData/memWrite/memRead out, memReadData in).
module mem_access_unit (
  input logic              clock,
  input logic              reset_n,
  mem_access_unit_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WRITE = 3'd2, DONE = 3'd3, FAULT = 3'd4;
  logic [2:0]  state_q, state_d, op_q;
  logic        st_q;
  logic [31:0] addr_q, sdata_q, word_q, load_q, load_d, mask, merged;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic        illegal, misaligned;
  always_comb begin
    illegal    = bus.isStore ? (bus.op > 3'd2) : (bus.op == 3'd3 || bus.op[2:1] == 2'b11);
    misaligned = (bus.op[1:0] == 2'd1 && bus.addr[0]) || (bus.op[1:0] == 2'd2 && bus.addr[1:0] != 2'd0);
    state_d = state_q == IDLE  ? (!bus.start ? IDLE :
                                  (illegal || misaligned) ? FAULT :
                                  (bus.isStore && bus.op[1:0] == 2'd2) ? WRITE : READ) :
              state_q == READ  ? (st_q ? WRITE : DONE) :
              state_q == WRITE ? DONE : IDLE;
    // lane shift: byte lanes step by 8 bits, halfword lanes by 16; zero for words
    sh     = op_q[1:0] == 2'd0 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    mask   = (op_q[1:0] == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = op_q[1:0] == 2'd2 ? sdata_q : (word_q & ~mask) | ((sdata_q << sh) & mask);
    lane   = 16'(bus.memReadData >> sh);
    // op[2] selects zero extension (lbu/lhu)
    load_d = op_q[1:0] == 2'd2 ? bus.memReadData :
             op_q[1:0] == 2'd1 ? {{16{~op_q[2] & lane[15]}}, lane} :
                                 {{24{~op_q[2] & lane[7]}}, lane[7:0]};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      word_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        op_q    <= bus.op;
        st_q    <= bus.isStore;
        addr_q  <= bus.addr;
        sdata_q <= bus.storeData;
      end
      if (state_q == READ) begin
        word_q <= bus.memReadData;
        if (!st_q) load_q <= load_d;
      end
    end
  end
  // strobes decode from state alone, so reset drops them immediately
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = state_q == DONE || state_q == FAULT;
  assign bus.fault        = state_q == FAULT;
  assign bus.memRead      = state_q == READ;
  assign bus.memWrite     = state_q == WRITE;
  assign bus.memAddress   = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.memWriteData = state_q == WRITE ? merged : 32'h0;
  assign bus.loadData     = load_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, hand sequences and random requests vs a byte-array model.
module tb_mem_access_unit;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  mem_access_unit_if bus();
  mem_access_unit dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  always @(posedge clock)
    if (pl_en) mem[pl_a] <= pl_d;
    else if (bus.memWrite) mem[bus.memAddress[7:2]] <= bus.memWriteData;
  assign bus.memReadData = bus.memRead ? mem[bus.memAddress[7:2]] : 32'h0;
  logic [7:0]  rb [256];
  logic [31:0] last_ld = '0;
  int total = 0, bad = 0;
  int o_lat;
  logic o_f, o_idle_ok, o_both;
  logic [31:0] o_ld, o_ma;
  logic [15:0] o_rd, o_wr;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic int nbytes(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction
  function automatic bit ref_fault(input bit st, input logic [2:0] op, input logic [31:0] a);
    bit legal = st ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a & 32'(nbytes(op) - 1)) != 0);
  endfunction
  function automatic int ref_lat(input bit st, input logic [2:0] op, input logic [31:0] a);
    if (ref_fault(st, op, a)) return 1;
    if (st && nbytes(op) < 4) return 3;
    return 2;
  endfunction
  function automatic logic [15:0] ref_rd(input bit st, input logic [2:0] op, input logic [31:0] a);
    if (ref_fault(st, op, a) || (st && nbytes(op) == 4)) return 16'h0;
    return 16'h2;
  endfunction
  function automatic logic [15:0] ref_wr(input bit st, input logic [2:0] op, input logic [31:0] a);
    if (ref_fault(st, op, a) || !st) return 16'h0;
    return nbytes(op) == 4 ? 16'h2 : 16'h4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = nbytes(op);
    for (int i = 0; i < n; i++) v |= 32'(rb[8'(a + 32'(i))]) << (8 * i);
    if (!op[2] && n < 4 && rb[8'(a + 32'(n - 1))][7]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v |= 32'(rb[{a[7:2], 2'b00} + 8'(i)]) << (8 * i);
    return v;
  endfunction
  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(op); i++) rb[8'(a + 32'(i))] = 8'(d >> (8 * i));
  endtask
  task automatic req(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.start = 1'b1; bus.isStore = st; bus.op = op; bus.addr = a; bus.storeData = d;
    o_lat = 0; o_f = 1'b0; o_ld = 'x; o_ma = 32'h0; o_rd = 0; o_wr = 0; o_idle_ok = 1'b1; o_both = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin
        bus.start = 1'b0; bus.isStore = 1'($urandom); bus.op = 3'($urandom);
        bus.addr = $urandom; bus.storeData = $urandom;
      end
      if (bus.memRead) o_rd |= 16'(1) << c;
      if (bus.memWrite) o_wr |= 16'(1) << c;
      if (bus.memRead && bus.memWrite) o_both = 1'b1;
      if (bus.memRead || bus.memWrite) o_ma = bus.memAddress;
      else if (bus.memAddress != 0 || bus.memWriteData != 0) o_idle_ok = 1'b0;
      if (bus.done) begin
        o_lat = c; o_f = bus.fault; o_ld = bus.loadData;
        break;
      end
    end
  endtask
  task automatic commit(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    if (ref_fault(st, op, a)) return;
    if (st) ref_store(op, a, d);
    else last_ld = ref_load(op, a);
  endtask
  typedef struct {
    bit st; logic [2:0] op; logic [31:0] a, d, ld; bit f; int lat; bit cm; logic [31:0] mw;
  } vec_t;
  vec_t tbl [16];
  initial begin
    bus.start = 1'b0; bus.isStore = 1'b0; bus.op = '0; bus.addr = '0; bus.storeData = '0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i == 4) ? 32'h80FF_7F01 : $urandom;
      for (int j = 0; j < 4; j++) rb[4 * i + j] = 8'(w >> (8 * j));
      @(negedge clock);
      pl_en = 1'b1; pl_a = 6'(i); pl_d = w;
    end
    @(negedge clock);
    pl_en = 1'b0;
    check("rst_flags", 32'({bus.busy, bus.done, bus.fault, bus.memWrite, bus.memRead}), 32'h0);
    check("rst_loadData", bus.loadData, 32'h0);
    check("rst_memAddress", bus.memAddress, 32'h0);
    check("rst_memWriteData", bus.memWriteData, 32'h0);
    reset_n = 1'b1;
    tbl = '{
      '{0, 3'd0, 32'h11, 32'h0,         32'h0000_007F, 0, 2, 0, 32'h0},
      '{0, 3'd0, 32'h13, 32'h0,         32'hFFFF_FF80, 0, 2, 0, 32'h0},
      '{0, 3'd4, 32'h12, 32'h0,         32'h0000_00FF, 0, 2, 0, 32'h0},
      '{0, 3'd1, 32'h12, 32'h0,         32'hFFFF_80FF, 0, 2, 0, 32'h0},
      '{1, 3'd2, 32'h20, 32'hDEAD_BEEF, 32'hFFFF_80FF, 0, 2, 1, 32'hDEAD_BEEF},
      '{0, 3'd2, 32'h20, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 32'h0},
      '{1, 3'd0, 32'h21, 32'hABCD_EF55, 32'hDEAD_BEEF, 0, 3, 1, 32'hDEAD_55EF},
      '{1, 3'd1, 32'h22, 32'h9988_1234, 32'hDEAD_BEEF, 0, 3, 1, 32'h1234_55EF},
      '{0, 3'd2, 32'h20, 32'h0,         32'h1234_55EF, 0, 2, 0, 32'h0},
      '{0, 3'd2, 32'h06, 32'h0,         32'h1234_55EF, 1, 1, 0, 32'h0},
      '{1, 3'd1, 32'h03, 32'h1111_1111, 32'h1234_55EF, 1, 1, 0, 32'h0},
      '{0, 3'd3, 32'h20, 32'h0,         32'h1234_55EF, 1, 1, 0, 32'h0},
      '{1, 3'd3, 32'h20, 32'h7777_7777, 32'h1234_55EF, 1, 1, 0, 32'h0},
      '{0, 3'd5, 32'h12, 32'h0,         32'h0000_80FF, 0, 2, 0, 32'h0},
      '{0, 3'd5, 32'h11, 32'h0,         32'h0000_80FF, 1, 1, 0, 32'h0},
      '{0, 3'd1, 32'h10, 32'h0,         32'h0000_7F01, 0, 2, 0, 32'h0}
    };
    foreach (tbl[i]) begin
      req(tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].d);
      check($sformatf("v%0d_lat", i), 32'(o_lat), 32'(tbl[i].lat));
      check($sformatf("v%0d_fault", i), 32'(o_f), 32'(tbl[i].f));
      check($sformatf("v%0d_loadData", i), o_ld, tbl[i].ld);
      check($sformatf("v%0d_rd_cycles", i), 32'(o_rd), 32'(ref_rd(tbl[i].st, tbl[i].op, tbl[i].a)));
      check($sformatf("v%0d_wr_cycles", i), 32'(o_wr), 32'(ref_wr(tbl[i].st, tbl[i].op, tbl[i].a)));
      if (o_rd != 0 || o_wr != 0) check($sformatf("v%0d_memAddress", i), o_ma, {tbl[i].a[31:2], 2'b00});
      check($sformatf("v%0d_idle_zero", i), 32'({o_idle_ok, o_both}), 32'h2);
      commit(tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].d);
      if (tbl[i].cm) check($sformatf("v%0d_mem", i), mem[tbl[i].a[7:2]], tbl[i].mw);
    end
    @(negedge clock);
    bus.start = 1'b1; bus.isStore = 1'b1; bus.op = 3'd2; bus.addr = 32'h20; bus.storeData = 32'hAAAA_AAAA;
    @(negedge clock);
    bus.start = 1'b0;
    check("abort_in_write", 32'(bus.memWrite), 32'h1);
    #1 reset_n = 1'b0;
    #1 check("abort_flags", 32'({bus.busy, bus.done, bus.fault, bus.memWrite, bus.memRead}), 32'h0);
    check("abort_buses", bus.memAddress | bus.memWriteData | bus.loadData, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    last_ld = 32'h0;
    check("abort_mem", mem[8], 32'h1234_55EF);
    @(negedge clock);
    bus.start = 1'b1; bus.isStore = 1'b0; bus.op = 3'd2; bus.addr = 32'h10;
    @(negedge clock);
    check("busy_first", 32'(bus.busy), 32'h1);
    bus.addr = 32'h20;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_done", 32'({bus.done, bus.fault}), 32'h2);
    check("busy_loadData", bus.loadData, 32'h80FF_7F01);
    last_ld = 32'h80FF_7F01;
    begin
      logic quiet = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        if (bus.busy || bus.done || bus.memRead) quiet = 1'b0;
      end
      check("start_ignored", 32'(quiet), 32'h1);
    end
    for (int n = 0; n < 60; n++) begin
      bit st; logic [2:0] op; logic [31:0] a, d, exp_ld; bit f;
      st = 1'($urandom); op = 3'($urandom_range(0, 7)); d = $urandom;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a &= ~(32'(nbytes(op)) - 1);
      f = ref_fault(st, op, a);
      exp_ld = (f || st) ? last_ld : ref_load(op, a);
      req(st, op, a, d);
      check($sformatf("r%0d_lat", n), 32'(o_lat), 32'(ref_lat(st, op, a)));
      check($sformatf("r%0d_fault", n), 32'(o_f), 32'(f));
      check($sformatf("r%0d_loadData", n), o_ld, exp_ld);
      check($sformatf("r%0d_strobes", n), {o_rd, o_wr}, {ref_rd(st, op, a), ref_wr(st, op, a)});
      check($sformatf("r%0d_idle_zero", n), 32'({o_idle_ok, o_both}), 32'h2);
      commit(st, op, a, d);
      if (st && !f) check($sformatf("r%0d_mem", n), mem[a[7:2]], ref_word(a));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the processor's MEM stage and the word-organised data memory. It accepts one byte, halfword or word request at a time and drives the memory's `memRead`/`memWrite` strobes. Sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended, and misaligned or illegal requests are rejected without any memory access.

## Interface
Parameters: none.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `start` in 1: request strobe, sampled only in IDLE.
- `isStore` in 1: 1 = store, 0 = load.
- `op` in 3: access size and extension.
  - Load encodings: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Store encodings: 000 sb, 001 sh, 010 sw.
- `addr` in 32: byte address.
- `storeData` in 32: store operand; the byte or halfword is taken from its low bits.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: high with `done` when a request is rejected.
- `loadData` out 32: extended load result, valid from the `done` cycle.
- `memAddress` out 32: word address `{addr[31:2],2'b00}`.
- `memWriteData` out 32: word to write.
- `memWrite` out 1: write strobe; memory writes on the rising edge.
- `memRead` out 1: read strobe.
- `memReadData` in 32: memory read data, combinational from `memAddress` while `memRead`=1.

## Operation
- States: IDLE, READ, WRITE, DONE, FAULT.
- Transitions from IDLE on `start`=1; the unit latches `isStore`, `op`, `addr` and `storeData` on that edge. Later changes to these inputs are ignored until the next IDLE.
  - Illegal op goes to FAULT: load op 011/110/111, or store op other than 000/001/010.
  - Misaligned access goes to FAULT: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Load or sub-word store goes to READ.
  - Word store goes to WRITE.
- READ: `memRead`=1 and `memAddress` is driven. At the edge, `memReadData` is captured into the word register.
  - A load then goes to DONE.
  - A sub-word store then goes to WRITE.
- WRITE: `memWrite`=1 and `memWriteData` is driven.
  - sw writes `storeData`.
  - sb/sh write the captured word with the addressed lane replaced: byte lane `addr[1:0]` (bits 8k+7:8k), or halfword lane `addr[1]` (bits 16h+15:16h).
  - Then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. For loads, `loadData` is updated on entry to DONE:
  - lb/lh sign-extend the selected lane.
  - lbu/lhu zero-extend the selected lane.
  - lw returns the whole word.
  - Lane ordering is little-endian.
- FAULT: `done`=1 and `fault`=1 for one cycle, then IDLE. No memory strobe is raised and `loadData` is unchanged.
- `start` while `busy`=1 is ignored and not queued.
- `memRead` and `memWrite` are never high together. When neither is high, `memAddress` and `memWriteData` are 0.
- `loadData` holds its value until the next successful load completes. Stores do not change it.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE, and all outputs are 0: `busy`, `done`, `fault`, `loadData`, `memAddress`, `memWriteData`, `memWrite`, `memRead`.
- Reset asserted mid-operation drops `memWrite`/`memRead` immediately, so no memory write occurs on the following edge. There is no `done` for the aborted request.
- Latency, counting the `start` edge as edge 0:
  - Load: `done` in cycle 2, after IDLE → READ → DONE.
  - sw: `done` in cycle 2, after IDLE → WRITE → DONE.
  - sb/sh: `done` in cycle 3, after READ → WRITE → DONE.
  - Fault: `done` in cycle 1.
- Back-to-back requests: a new `start` is accepted in the cycle after `done`, once the unit is back in IDLE. Minimum issue interval is 3 cycles for loads.
- All outputs are registered or decoded from state only. There is no combinational path from `start` to the memory strobes.

## Test plan
- Preload word 0x80FF7F01 at address 0x10.
  - lb @0x11 → `loadData`=0x0000007F.
  - lb @0x13 → 0xFFFFFF80.
  - lbu @0x12 → 0x000000FF.
  - lh @0x12 → 0xFFFF80FF.
  - Each completes with `done` in cycle 2.
- sw 0xDEADBEEF @0x20, then lw @0x20 → 0xDEADBEEF. Check `memWrite` is high exactly one cycle and `memAddress`=0x20.
- With 0xDEADBEEF at 0x20:
  - sb 0x55 @0x21 → memory word 0xDEAD55EF; `done` in cycle 3, `memRead` in cycle 1, `memWrite` in cycle 2.
  - Then sh 0x1234 @0x22 → 0x123455EF.
- lw @0x06, sh @0x03, and load op 011 → `fault`=`done`=1 in cycle 1. `memRead`/`memWrite` stay 0, and `loadData` keeps its previous value.
- Pulse `reset_n` low during WRITE of an sw → no memory change, all outputs 0 at once, and `busy`=0. Then issue `start` with lw @0x20 while a prior request is still busy → that `start` is ignored.
